// File: rtl/rr_arbiter_pkg.sv
// Shared types for the round-robin arbiter slice.
// Only the FSM state encoding lives here; vector/index types stay local to the top.
package rr_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter_enc.sv
// One-hot to binary encoder; an all-zero input encodes to index 0.
module rr_arbiter_enc #(
    parameter int NUM_WIRE = 16
) (
    input  logic [NUM_WIRE-1:0]         onehot_i,
    output logic [$clog2(NUM_WIRE)-1:0] idx_o
);

    localparam int IDX_W = $clog2(NUM_WIRE);

    // OR of every set position; exact as long as the input is one-hot.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < NUM_WIRE; i++) begin
            if (onehot_i[i]) begin
                idx_o = idx_o | IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered, non-retracting grant held until the
// consumer accepts it; a new grant may be presented on every accepting edge.
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic                       gnt_ready_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
    output logic                       gnt_valid_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef logic [NUM_REQ-1:0] reqVec_t;
    typedef logic [IDX_W-1:0]   reqIdx_t;

    arb_state_e state_q, state_d;
    reqVec_t    gnt_q, gnt_d;
    reqIdx_t    gntIdx_q, gntIdx_d;
    reqIdx_t    ptr_q, ptr_d;

    logic       handshake;
    logic       loadEdge;
    logic       anyReq;
    reqIdx_t    base;
    reqVec_t    nextGnt;
    reqIdx_t    nextIdx;

    assign handshake = (state_q == HOLD) && gnt_ready_i;
    assign loadEdge  = (state_q == IDLE) || handshake;
    assign anyReq    = |req_i;

    // NUM_REQ is a power of two, so plain truncation gives the modulo wrap.
    assign base = (handshake ? gntIdx_q : ptr_q) + reqIdx_t'(1);

    // First requester at or above base, wrapping past the top index.
    always_comb begin
        logic    found;
        reqIdx_t scanIdx;
        nextGnt = '0;
        found   = 1'b0;
        scanIdx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scanIdx = base + reqIdx_t'(i);
            if (!found && req_i[scanIdx]) begin
                nextGnt[scanIdx] = 1'b1;
                found            = 1'b1;
            end
        end
    end

    rr_arbiter_enc #(
        .NUM_WIRE (NUM_REQ)
    ) u_enc (
        .onehot_i (nextGnt),
        .idx_o    (nextIdx)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gntIdx_d = gntIdx_q;
        ptr_d    = ptr_q;
        if (handshake) begin
            ptr_d = gntIdx_q;
        end
        if (loadEdge) begin
            gnt_d    = nextGnt;
            gntIdx_d = nextIdx;
            state_d  = anyReq ? HOLD : IDLE;
        end
    end

    // Pointer resets to the top index so requester 0 wins the first scan.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gntIdx_q <= '0;
            ptr_q    <= reqIdx_t'(NUM_REQ - 1);
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gntIdx_q <= gntIdx_d;
            ptr_q    <= ptr_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = gntIdx_q;
    assign gnt_valid_o = (state_q == HOLD);

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter (NUM_REQ=16): directed scenarios plus a
// randomized run compared against a simple round-robin reference model.
module tb_rr_arbiter;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic         ready;
    logic [N-1:0] gnt_o;
    logic [3:0]   gnt_idx_o;
    logic         gnt_valid_o;

    int checks = 0;
    int errors = 0;

    bit mValid;
    int mIdx;
    int mPtr;

    rr_arbiter #(
        .NUM_REQ (N)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .gnt_ready_i (ready),
        .gnt_o       (gnt_o),
        .gnt_idx_o   (gnt_idx_o),
        .gnt_valid_o (gnt_valid_o)
    );

    always #5 clk = ~clk;

    // Reference: round-robin scan starting one past the last accepted index.
    task automatic modelEdge();
        int  start;
        bit  hs;
        if (!rst_n) begin
            mValid = 1'b0;
            mIdx   = 0;
            mPtr   = N - 1;
        end else begin
            hs = mValid && ready;
            if (!mValid || hs) begin
                start  = ((hs ? mIdx : mPtr) + 1) % N;
                if (hs) mPtr = mIdx;
                mValid = 1'b0;
                mIdx   = 0;
                for (int j = 0; j < N; j++) begin
                    if (req[(start + j) % N]) begin
                        mValid = 1'b1;
                        mIdx   = (start + j) % N;
                        break;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic test_reset();
        logic [3:0]   eIdx;
        logic [N-1:0] eGnt;
        rst_n = 1'b0;
        req   = N'($urandom);
        ready = 1'b1;
        tick();
        tick();
        checks++;
        if ({gnt_valid_o, gnt_idx_o, gnt_o} !== 21'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got valid=%0b idx=%0d gnt=%h, expected all zero",
                     gnt_valid_o, gnt_idx_o, gnt_o);
        end
        rst_n = 1'b1;
        req   = 16'hFFFF;
        ready = 1'b1;
        for (int k = 0; k <= N; k++) begin
            tick();
            eIdx = 4'(k % N);
            eGnt = 16'h1 << eIdx;
            checks++;
            if (gnt_valid_o !== 1'b1 || gnt_idx_o !== eIdx || gnt_o !== eGnt) begin
                errors++;
                $display("[TB] FAIL reset_sweep[%0d]: got valid=%0b idx=%0d gnt=%h, expected valid=1 idx=%0d gnt=%h",
                         k, gnt_valid_o, gnt_idx_o, gnt_o, eIdx, eGnt);
            end
        end
    endtask

    task automatic test_hold();
        req   = 16'h0010;
        ready = 1'b1;
        tick();
        checks++;
        if (gnt_valid_o !== 1'b1 || gnt_idx_o !== 4'd4 || gnt_o !== 16'h0010) begin
            errors++;
            $display("[TB] FAIL hold_first: got valid=%0b idx=%0d gnt=%h, expected valid=1 idx=4 gnt=0010",
                     gnt_valid_o, gnt_idx_o, gnt_o);
        end
        ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            req = (c >= 2) ? 16'h0000 : 16'h0010;
            tick();
            checks++;
            if (gnt_valid_o !== 1'b1 || gnt_idx_o !== 4'd4 || gnt_o !== 16'h0010) begin
                errors++;
                $display("[TB] FAIL hold_stable[%0d]: got valid=%0b idx=%0d gnt=%h, expected valid=1 idx=4 gnt=0010",
                         c, gnt_valid_o, gnt_idx_o, gnt_o);
            end
        end
        ready = 1'b1;
        req   = 16'h0000;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (gnt_valid_o !== 1'b0 || gnt_idx_o !== 4'd0 || gnt_o !== 16'h0000) begin
                errors++;
                $display("[TB] FAIL hold_release[%0d]: got valid=%0b idx=%0d gnt=%h, expected idle zeros",
                         c, gnt_valid_o, gnt_idx_o, gnt_o);
            end
        end
    endtask

    task automatic test_wrap();
        logic [3:0]   expIdx [3] = '{4'd15, 4'd0, 4'd15};
        logic [15:0]  expReq [3] = '{16'h8000, 16'h8001, 16'h8001};
        bit           expRdy [3] = '{1'b0, 1'b1, 1'b1};
        for (int s = 0; s < 3; s++) begin
            req   = expReq[s];
            ready = expRdy[s];
            tick();
            checks++;
            if (gnt_valid_o !== 1'b1 || gnt_idx_o !== expIdx[s] || gnt_o !== (16'h1 << expIdx[s])) begin
                errors++;
                $display("[TB] FAIL wrap[%0d]: got valid=%0b idx=%0d gnt=%h, expected idx=%0d",
                         s, gnt_valid_o, gnt_idx_o, gnt_o, expIdx[s]);
            end
        end
        req   = 16'h0000;
        ready = 1'b1;
        tick();
        checks++;
        if (gnt_valid_o !== 1'b0 || gnt_o !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL wrap_idle: got valid=%0b gnt=%h, expected valid=0 gnt=0000",
                     gnt_valid_o, gnt_o);
        end
    endtask

    task automatic test_single();
        req   = 16'h0200;
        ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (gnt_valid_o !== 1'b1 || gnt_idx_o !== 4'd9 || gnt_o !== 16'h0200) begin
                errors++;
                $display("[TB] FAIL single[%0d]: got valid=%0b idx=%0d gnt=%h, expected valid=1 idx=9 gnt=0200",
                         c, gnt_valid_o, gnt_idx_o, gnt_o);
            end
        end
    endtask

    task automatic test_mid_reset();
        req   = 16'h0000;
        ready = 1'b1;
        tick();
        req   = 16'h0080;
        ready = 1'b0;
        tick();
        checks++;
        if (gnt_valid_o !== 1'b1 || gnt_idx_o !== 4'd7 || gnt_o !== 16'h0080) begin
            errors++;
            $display("[TB] FAIL midreset_hold: got valid=%0b idx=%0d gnt=%h, expected valid=1 idx=7",
                     gnt_valid_o, gnt_idx_o, gnt_o);
        end
        rst_n = 1'b0;
        ready = 1'b1;
        tick();
        checks++;
        if ({gnt_valid_o, gnt_idx_o, gnt_o} !== 21'b0) begin
            errors++;
            $display("[TB] FAIL midreset_clear: got valid=%0b idx=%0d gnt=%h, expected all zero",
                     gnt_valid_o, gnt_idx_o, gnt_o);
        end
        rst_n = 1'b1;
        ready = 1'b0;
        tick();
        checks++;
        if (gnt_valid_o !== 1'b1 || gnt_idx_o !== 4'd7 || gnt_o !== 16'h0080) begin
            errors++;
            $display("[TB] FAIL midreset_regrant: got valid=%0b idx=%0d gnt=%h, expected valid=1 idx=7",
                     gnt_valid_o, gnt_idx_o, gnt_o);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] flip;
        logic [N-1:0] reqEdge;
        logic [N-1:0] expGnt;
        bit           hsEdge;
        int           hsIdx;
        int           waits [N];
        int           maxWait = 0;
        int           printed = 0;
        int           handshakes = 0;
        for (int k = 0; k < N; k++) waits[k] = 0;
        for (int cyc = 0; cyc < 1600; cyc++) begin
            flip = '0;
            for (int k = 0; k < N; k++) flip[k] = ($urandom_range(0, 7) == 0);
            req = req ^ flip;
            if ($urandom_range(0, 49) == 0) req = '0;
            ready   = ($urandom_range(0, 3) != 0);
            reqEdge = req;
            hsEdge  = gnt_valid_o && ready;
            hsIdx   = int'(gnt_idx_o);
            tick();
            if (hsEdge) handshakes++;
            expGnt = mValid ? (N'(1) << mIdx) : '0;
            checks++;
            if (gnt_valid_o !== mValid || gnt_idx_o !== 4'(mIdx) || gnt_o !== expGnt) begin
                errors++;
                if (printed < 20) begin
                    printed++;
                    $display("[TB] FAIL random_model[%0d]: got valid=%0b idx=%0d gnt=%h, expected valid=%0b idx=%0d gnt=%h",
                             cyc, gnt_valid_o, gnt_idx_o, gnt_o, mValid, mIdx, expGnt);
                end
            end
            checks++;
            if ($countones(gnt_o) !== (gnt_valid_o ? 1 : 0)) begin
                errors++;
                if (printed < 20) begin
                    printed++;
                    $display("[TB] FAIL random_onehot[%0d]: got gnt=%h valid=%0b, expected one-hot when valid else zero",
                             cyc, gnt_o, gnt_valid_o);
                end
            end
            for (int k = 0; k < N; k++) begin
                if (!reqEdge[k]) waits[k] = 0;
                else if (hsEdge && hsIdx != k) waits[k]++;
                if (gnt_valid_o && int'(gnt_idx_o) == k) waits[k] = 0;
                if (waits[k] > maxWait) maxWait = waits[k];
            end
        end
        checks++;
        if (maxWait > N) begin
            errors++;
            $display("[TB] FAIL random_fairness: got max wait %0d handshakes, expected at most %0d",
                     maxWait, N);
        end
        $display("[TB] random run: %0d handshakes, max wait %0d", handshakes, maxWait);
    endtask

    initial begin
        rst_n  = 1'b0;
        req    = '0;
        ready  = 1'b0;
        mValid = 1'b0;
        mIdx   = 0;
        mPtr   = N - 1;
        test_reset();
        test_hold();
        test_wrap();
        test_single();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 16, giving the number of requesters (power of two, at least 2).
REQ-002 SHALL have port clk_i, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1 bit, reset that is synchronous and active-low.
REQ-004 SHALL have port req_i, input, NUM_REQ bits; bit k high means requester k requests.
REQ-005 SHALL have port gnt_ready_i, input, 1 bit; high means the consumer accepts the current grant.
REQ-006 SHALL have port gnt_o, output, NUM_REQ bits, the registered one-hot grant vector.
REQ-007 SHALL have port gnt_idx_o, output, $clog2(NUM_REQ) bits, the binary index of the set bit of gnt_o.
REQ-008 SHALL have port gnt_valid_o, output, 1 bit; high means gnt_o/gnt_idx_o hold a grant.

Function
REQ-009 SHALL use states IDLE (gnt_valid_o=0) and HOLD (gnt_valid_o=1).
REQ-010 SHALL perform a handshake on any rising edge where gnt_valid_o=1 and gnt_ready_i=1.
REQ-011 SHALL keep register ptr_q, the index of the last handshaken grant.
REQ-012 SHALL arbitrate on an edge where the state is IDLE or a handshake occurs (load edge).
REQ-013 SHALL compute base = (handshake ? gnt_idx_o : ptr_q) + 1 modulo NUM_REQ, wrapping NUM_REQ-1 to 0.
REQ-014 SHALL grant on a load edge the first set bit of req_i scanning upward from base with wrap-around.
REQ-015 SHALL register that grant into gnt_o/gnt_idx_o and enter HOLD when any req_i bit is set at a load edge.
REQ-016 SHALL clear gnt_o, set gnt_idx_o to 0 and enter IDLE when req_i is all zero at a load edge.
REQ-017 SHALL show a grant one cycle after req_i is sampled.
REQ-018 SHALL keep gnt_o and gnt_idx_o stable in HOLD until a handshake, even if the granted req_i bit drops (no retraction).
REQ-019 SHALL ignore req_i changes in HOLD without a handshake.
REQ-020 SHALL load ptr_q with gnt_idx_o on a handshake, and at the same edge present the next grant (one grant per cycle back-to-back).
REQ-021 SHALL regrant the same requester after a handshake when it is the only requester.
REQ-022 SHALL keep gnt_o one-hot whenever gnt_valid_o=1 and all zero whenever gnt_valid_o=0.
REQ-023 SHALL keep gnt_idx_o equal to the encoded position of the gnt_o bit.
REQ-024 SHALL ignore gnt_ready_i in IDLE.
REQ-025 SHALL grant every continuously asserting requester within NUM_REQ handshakes.

Reset
REQ-026 SHALL on a rising edge with rst_ni=0 set gnt_o to 0, gnt_idx_o to 0, gnt_valid_o to 0, ptr_q to NUM_REQ-1 and state to IDLE, overriding any handshake.
REQ-027 SHALL make requester 0 highest priority for the first grant after reset.
REQ-028 SHALL drop an unaccepted grant when reset is applied mid-HOLD; no handshake is counted.

Structure
REQ-029 SHALL keep the request-vector and index typedefs local to the module; no shared package entry is required.
REQ-030 SHALL derive gnt_idx_o by instantiating the existing encoder sub-module (NUM_WIRE=NUM_REQ) on the next-grant vector.
REQ-031 SHALL contain no latches and no combinational path from gnt_ready_i to any output.

Verification (NUM_REQ=16)
REQ-032 SHALL test reset: after reset, req_i=0xFFFF, ready=1 -> grants 0,1,2,...,15,0 on consecutive cycles.
REQ-033 SHALL test hold: req_i=0x0010, ready=0 for 5 cycles with req dropped at cycle 2 -> gnt_o=0x0010, idx=4 stable; handshake then IDLE.
REQ-034 SHALL test wrap: grant idx 15 handshaken, req_i=0x8001 -> next grant idx 0, then idx 15.
REQ-035 SHALL test single requester: req_i=0x0200, ready=1 -> idx 9 granted every cycle, valid continuous.
REQ-036 SHALL test mid-HOLD reset: HOLD on idx 7, rst_ni low one edge -> outputs 0; with req_i=0x0080 the next grant is idx 7.
REQ-037 SHALL test random stress: random req_i/ready for 1600 cycles -> one-hot, index match, no retraction, fairness bound all hold.
